// File: rtl/store_exec_unit.sv
// Store execute/memory stage: computes the effective address of a decoded store and
// drives one or two word-aligned, byte-strobed write beats over a valid/ready handshake.
module store_exec_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_rs2_val,
  input  logic [11:0] i_imm,
  input  logic [2:0]  i_store_control,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  output logic        o_store_done,
  output logic        o_store_err
);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e      r_state, w_state_next;
  logic [29:0] r_word;
  logic [7:0]  r_strb;
  logic [63:0] r_data;
  logic        r_done, r_err;

  logic [31:0] w_ea;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [7:0]  w_strb8;
  logic [63:0] w_data_raw, w_data64;
  logic        w_accept, w_reject, w_done_next;

  always_comb begin
    w_ea  = i_rs1_val + {{20{i_imm[11]}}, i_imm};
    w_off = w_ea[1:0];
    case (i_store_control)
      3'd1:    w_mask = 4'h3;
      3'd2:    w_mask = 4'hF;
      default: w_mask = 4'h1;
    endcase
    w_strb8    = {4'b0000, w_mask} << w_off;
    w_data_raw = {32'h0, i_rs2_val} << {w_off, 3'b000};
    // Zero every lane whose strobe is clear so idle lanes never carry stale rs2 bytes.
    for (int i = 0; i < 8; i++) begin
      w_data64[8*i +: 8] = w_strb8[i] ? w_data_raw[8*i +: 8] : 8'h00;
    end
  end

  assign o_req_ready = (r_state == StIdle) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_reject    = w_accept && (|w_strb8[7:4]) && !ALLOW_MISALIGNED;

  always_comb begin
    w_state_next = r_state;
    w_done_next  = w_reject;
    case (r_state)
      StIdle: begin
        if (w_accept && !w_reject) w_state_next = StBeat0;
      end
      StBeat0: begin
        if (i_mem_ready) begin
          if (|r_strb[7:4]) begin
            w_state_next = StBeat1;
          end else begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end
        end
      end
      StBeat1: begin
        if (i_mem_ready) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_strb  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_err   <= w_reject;
      if (w_accept) begin
        r_word <= w_ea[31:2];
        r_strb <= w_strb8;
        r_data <= w_data64;
      end
    end
  end

  always_comb begin
    o_mem_valid = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wstrb = 4'h0;
    o_mem_wdata = 32'h0;
    case (r_state)
      StBeat0: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {r_word, 2'b00};
        o_mem_wstrb = r_strb[3:0];
        o_mem_wdata = r_data[31:0];
      end
      StBeat1: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {r_word + 30'd1, 2'b00};
        o_mem_wstrb = r_strb[7:4];
        o_mem_wdata = r_data[63:32];
      end
      default: ;
    endcase
  end

  assign o_store_done = r_done;
  assign o_store_err  = r_err;

endmodule

// File: doc/store_exec_unit.md
Name: store_exec_unit

Overview:
- Execute/memory stage that sits directly downstream of the store decoder.
- Takes the decoded store (rs1 value, rs2 value, 12-bit immediate, store_control) and computes the effective address.
- Generates word-aligned write beats with byte strobes and drives them to data memory over a valid/ready handshake.
- Misaligned halfword/word stores are split into two word beats, or flagged as an error, depending on a parameter.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split stores that cross a word boundary into two beats; 0 = reject misaligned SH/SW with store_err.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  decoded store available
- req_ready  out  1  unit can accept a store
- rs1_val  in  32  base register value
- rs2_val  in  32  store data register value
- imm  in  12  signed store offset, as produced by the decoder
- store_control  in  3  shared store encoding: `SB=0, `SH=1, `SW=2; any other value is treated as `SB
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts the beat
- mem_addr  out  32  word-aligned address; bits [1:0] always 0
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte strobes; bit i = byte lane i
- store_done  out  1  one-cycle pulse: store fully retired
- store_err  out  1  one-cycle pulse: misaligned store rejected (ALLOW_MISALIGNED=0 only)

Behaviour:
- Reset: state IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, store_done=0, store_err=0. req_ready=0 while rst=1.
- A reset asserted mid-store abandons the store:
  - mem_valid=0 from the next edge;
  - no store_done or store_err for the abandoned store.
- States: IDLE, BEAT0, BEAT1.
- req_ready = (state==IDLE) && !rst.
- Accept: when req_valid && req_ready at edge T, the unit registers:
  - ea = rs1_val + sign_extend(imm), mod 2^32;
  - off = ea[1:0];
  - size mask = 0x1 for SB, 0x3 for SH, 0xF for SW;
  - strb8 = mask << off (8 bits);
  - data64 = rs2_val << (8*off) (64 bits; unused lanes zero).
- Beat 0: mem_addr = {ea[31:2],2'b00}, mem_wstrb = strb8[3:0], mem_wdata = data64[31:0].
- Beat 1 exists iff strb8[7:4] != 0: mem_addr = beat0 addr + 4 (wraps 0xFFFFFFFC -> 0x00000000), mem_wstrb = strb8[7:4], mem_wdata = data64[63:32].
- IDLE -> BEAT0 on accept. mem_valid=1 from T+1.
- BEAT0 on mem_ready:
  - goes to BEAT1 if beat 1 exists; beat-1 values are presented the next cycle with mem_valid still 1;
  - otherwise goes to IDLE.
- BEAT1 on mem_ready -> IDLE.
- store_done pulses for exactly one cycle, in the cycle after the final mem handshake. That same cycle: state=IDLE, req_ready=1, mem_valid=0.
  - Minimum aligned latency: accept at T, beat at T+1, done at T+2.
- Back-pressure: while mem_valid=1 && mem_ready=0, mem_addr, mem_wdata and mem_wstrb hold stable. mem_valid never drops before its handshake.
- mem_wdata lanes with strobe 0 are driven to 0. mem_wstrb=0 and mem_wdata=0 whenever mem_valid=0.
- ALLOW_MISALIGNED=0, for SH with off==3, or SW with off!=0:
  - no beat is issued;
  - store_err and store_done both pulse at T+1;
  - state returns to IDLE at T+1.
  - SH at off 1 is within-word and is legal in both modes.
- Inputs are sampled only at the accept edge; changes to them afterwards have no effect on the in-flight store.
- No accepts occur while busy: req_ready=0 in BEAT0/BEAT1.

Test Plan:
- SB: rs1=0x1000, imm=0x003, rs2=0xAABBCCDD -> one beat, addr 0x1000, wstrb 4'b1000, wdata 0xDD000000. store_done at T+2 with mem_ready tied 1.
- SW with negative imm: rs1=0x2000, imm=0xFFC, rs2=0x12345678 -> addr 0x1FFC, wstrb 4'b1111, wdata 0x12345678. Single beat.
- Misaligned SW, ALLOW_MISALIGNED=1: rs1=0x1002, imm=0, rs2=0x11223344.
  - beat0: addr 0x1000, wstrb 1100, wdata 0x33440000;
  - beat1: addr 0x1004, wstrb 0011, wdata 0x00001122;
  - one store_done.
- SH crossing a word: rs1=0xFFFFFFFF, imm=0, rs2=0x0000BEEF.
  - beat0: addr 0xFFFFFFFC, wstrb 1000, wdata 0xEF000000;
  - beat1: addr 0x00000000 (wrap), wstrb 0001, wdata 0x000000BE.
- Back-pressure and reset: hold mem_ready=0 for 3 cycles on beat0 -> outputs stable, req_ready=0. Assert rst during beat1 -> mem_valid=0 next cycle, no store_done, req_ready=1 the cycle after rst deasserts.
- ALLOW_MISALIGNED=0: SW at 0x1002 -> mem_valid stays 0; store_err=store_done=1 at T+1 for one cycle. A following aligned SW is accepted and completes normally.
